matrix_cfg_loader: RTL and testbench

MATRIX_CFG_LOADER -- requirements
Module: matrix_cfg_loader

---
 rtl/matrix_cfg_loader.sv | 196 +++++++++++++++++++
 tb/tb_matrix_cfg_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_cfg_loader.sv
// Serial loader for the switch-matrix routing words: header hunt, word capture, range check, atomic commit.
// Optional per-word even-parity bit is enabled with `define MATRIX_CFG_PARITY_EN.
module matrix_cfg_loader #(
    parameter int NH = 5,
    parameter int NV = 4,
    parameter int WB = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_valid,
    input  logic                         cfg_bit,
    output logic                         cfg_ready,
    input  logic                         cfg_clr,
    output logic [(2*NH+2*NV)*WB-1:0]    cfg_q,
    output logic                         cfg_done,
    output logic                         cfg_err,
    output logic                         cfg_busy
);

    localparam int NW = 2*NH + 2*NV;
`ifdef MATRIX_CFG_PARITY_EN
    localparam int LW = WB + 1;
`else
    localparam int LW = WB;
`endif
    localparam int BCW = (LW > 1) ? $clog2(LW) : 1;
    localparam int WCW = (NW > 1) ? $clog2(NW) : 1;
    localparam int IW  = WB - 3;

    localparam logic [BCW-1:0] BIT_LAST  = BCW'(LW - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(NW - 1);
    localparam logic [31:0]    NH_U      = NH;
    localparam logic [31:0]    NV_U      = NV;
    localparam logic [7:0]     HDR       = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT,
        S_ERR
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    // Only the last 7 header bits need storing; the incoming bit completes the 8-bit window.
    logic [6:0]            r_hdr;
    logic [LW-2:0]         r_word;
    logic [BCW-1:0]        r_bitcnt;
    logic [WCW-1:0]        r_wordcnt;
    logic [WB-1:0]         r_shadow [NW];
    logic [NW*WB-1:0]      r_q;
    logic                  r_done;
    logic                  r_err;

    logic                  w_acc;
    logic [7:0]            w_hdr_nxt;
    logic [LW-1:0]         w_shift;
    logic [WB-1:0]         w_data;
    logic                  w_word_end;
    logic                  w_frame_end;
    logic                  w_range_ok;
    logic                  w_word_ok;

    function automatic logic range_ok(input logic [2:0] side, input logic [IW-1:0] idx);
        logic [31:0] i;
        i = 32'(idx);
        case (side)
            3'd0:       range_ok = 1'b1;
            3'd1, 3'd3: range_ok = (i < NH_U);
            3'd2, 3'd4: range_ok = (i < NV_U);
            default:    range_ok = 1'b0;
        endcase
    endfunction

    assign cfg_ready   = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign cfg_busy    = (r_state == S_LOAD) || (r_state == S_COMMIT);
    assign cfg_q       = r_q;
    assign cfg_done    = r_done;
    assign cfg_err     = r_err;

    assign w_acc       = cfg_valid && cfg_ready;
    assign w_hdr_nxt   = {r_hdr, cfg_bit};
    assign w_shift     = {r_word, cfg_bit};
    assign w_data      = w_shift[LW-1 -: WB];
    assign w_word_end  = (r_bitcnt == BIT_LAST);
    assign w_frame_end = (r_wordcnt == WORD_LAST);
    assign w_range_ok  = range_ok(w_data[2:0], w_data[WB-1:3]);

`ifdef MATRIX_CFG_PARITY_EN
    // Data bits plus the trailing parity bit must XOR to zero.
    assign w_word_ok   = w_range_ok && !(^w_shift);
`else
    assign w_word_ok   = w_range_ok;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_acc && (w_hdr_nxt == HDR)) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_acc && w_word_end) begin
                    if (!w_word_ok) begin
                        w_state_nxt = S_ERR;
                    end else if (w_frame_end) begin
                        w_state_nxt = S_COMMIT;
                    end
                end
            end
            S_COMMIT: w_state_nxt = S_IDLE;
            S_ERR:    w_state_nxt = S_ERR;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (cfg_clr) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Datapath: cfg_clr wins over any accepted bit and over the commit itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hdr     <= '0;
            r_word    <= '0;
            r_bitcnt  <= '0;
            r_wordcnt <= '0;
            r_q       <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            for (int k = 0; k < NW; k++) begin
                r_shadow[k] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            if (cfg_clr) begin
                r_hdr     <= '0;
                r_word    <= '0;
                r_bitcnt  <= '0;
                r_wordcnt <= '0;
                r_err     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_acc) begin
                            if (w_hdr_nxt == HDR) begin
                                r_hdr     <= '0;
                                r_word    <= '0;
                                r_bitcnt  <= '0;
                                r_wordcnt <= '0;
                            end else begin
                                r_hdr <= w_hdr_nxt[6:0];
                            end
                        end
                    end
                    S_LOAD: begin
                        if (w_acc) begin
                            r_word <= w_shift[LW-2:0];
                            if (w_word_end) begin
                                r_bitcnt <= '0;
                                if (w_word_ok) begin
                                    r_shadow[r_wordcnt] <= w_data;
                                    r_wordcnt <= w_frame_end ? '0 : r_wordcnt + 1'b1;
                                end else begin
                                    r_err <= 1'b1;
                                end
                            end else begin
                                r_bitcnt <= r_bitcnt + 1'b1;
                            end
                        end
                    end
                    S_COMMIT: begin
                        for (int k = 0; k < NW; k++) begin
                            r_q[k*WB +: WB] <= r_shadow[k];
                        end
                        r_done <= 1'b1;
                        r_hdr  <= '0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matrix_cfg_loader.sv
// Directed bench for matrix_cfg_loader: reset, legal commit, range errors, stalls/abort, mid-frame reset.
module tb_matrix_cfg_loader;

    localparam int NH = 5;
    localparam int NV = 4;
    localparam int WB = 6;
    localparam int NW = 2*NH + 2*NV;
    localparam int QW = NW*WB;
`ifdef MATRIX_CFG_PARITY_EN
    localparam int LW = WB + 1;
`else
    localparam int LW = WB;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_bit = 1'b0;
    logic          cfg_clr = 1'b0;
    logic          cfg_ready;
    logic [QW-1:0] cfg_q;
    logic          cfg_done;
    logic          cfg_err;
    logic          cfg_busy;

    int            n_total = 0;
    int            n_bad = 0;
    int            done_cnt = 0;
    logic [QW-1:0] exp_q;
    logic [QW-1:0] exp_pat;

    matrix_cfg_loader #(.NH(NH), .NV(NV), .WB(WB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_valid(cfg_valid),
        .cfg_bit(cfg_bit),
        .cfg_ready(cfg_ready),
        .cfg_clr(cfg_clr),
        .cfg_q(cfg_q),
        .cfg_done(cfg_done),
        .cfg_err(cfg_err),
        .cfg_busy(cfg_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && cfg_done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [LW-1:0] enc(input logic [WB-1:0] w);
`ifdef MATRIX_CFG_PARITY_EN
        enc = {w, ^w};
`else
        enc = w;
`endif
    endfunction

    // Legal pattern: top {k,1}, bottom {k,3} (last one disconnected idx 7), left {k,2}, right {k,4}.
    function automatic logic [WB-1:0] pat(input int k);
        if (k < 5)       pat = {3'(k), 3'd1};
        else if (k == 9) pat = {3'd7, 3'd0};
        else if (k < 10) pat = {3'(k-5), 3'd3};
        else if (k < 14) pat = {3'(k-10), 3'd2};
        else             pat = {3'(k-14), 3'd4};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        cfg_valid = 1'b1;
        cfg_bit   = b;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic send_header(input int gap);
        logic [7:0] h;
        h = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            if (gap > 0) idle($urandom_range(0, gap));
            send_bit(h[i]);
        end
    endtask

    task automatic send_word(input logic [WB-1:0] w, input int gap);
        logic [LW-1:0] e;
        e = enc(w);
        for (int i = LW-1; i >= 0; i--) begin
            if (gap > 0) idle($urandom_range(0, gap));
            send_bit(e[i]);
        end
    endtask

    task automatic do_clr();
        cfg_clr = 1'b1;
        @(posedge clk);
        #1;
        cfg_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        n_total++; if (cfg_q !== '0) begin n_bad++; $display("FAIL reset_q: got %h want 0", cfg_q); end
        n_total++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
        n_total++; if (cfg_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", cfg_busy); end
        n_total++; if (cfg_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", cfg_done); end
        n_total++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", cfg_err); end
    endtask

    task automatic test_legal();
        send_header(0);
        n_total++; if (cfg_busy !== 1'b1) begin n_bad++; $display("FAIL legal_busy_load: got %b want 1", cfg_busy); end
        send_word(6'b010010, 0);
        for (int k = 1; k < NW; k++) send_word('0, 0);
        n_total++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL legal_ready_commit: got %b want 0", cfg_ready); end
        n_total++; if (cfg_done !== 1'b0) begin n_bad++; $display("FAIL legal_done_early: got %b want 0", cfg_done); end
        n_total++; if (cfg_q !== '0) begin n_bad++; $display("FAIL legal_q_early: got %h want 0", cfg_q); end
        idle(1);
        exp_q = '0;
        exp_q[5:0] = 6'b010010;
        n_total++; if (cfg_q !== exp_q) begin n_bad++; $display("FAIL legal_q: got %h want %h", cfg_q, exp_q); end
        n_total++; if (cfg_done !== 1'b1) begin n_bad++; $display("FAIL legal_done: got %b want 1", cfg_done); end
        n_total++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL legal_err: got %b want 0", cfg_err); end
        n_total++; if (cfg_busy !== 1'b0) begin n_bad++; $display("FAIL legal_busy_after: got %b want 0", cfg_busy); end
        idle(1);
        n_total++; if (cfg_done !== 1'b0) begin n_bad++; $display("FAIL legal_done_width: got %b want 0", cfg_done); end
    endtask

    task automatic test_illegal_side();
        logic [LW-1:0] e;
        e = enc(6'b000101);
        send_header(0);
        for (int i = LW-1; i >= 1; i--) send_bit(e[i]);
        n_total++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL side_err_early: got %b want 0", cfg_err); end
        send_bit(e[0]);
        n_total++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL side_err: got %b want 1", cfg_err); end
        n_total++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL side_ready: got %b want 0", cfg_ready); end
        n_total++; if (cfg_busy !== 1'b0) begin n_bad++; $display("FAIL side_busy: got %b want 0", cfg_busy); end
        idle(4);
        n_total++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL side_err_sticky: got %b want 1", cfg_err); end
        n_total++; if (cfg_q !== exp_q) begin n_bad++; $display("FAIL side_q_kept: got %h want %h", cfg_q, exp_q); end
        do_clr();
        n_total++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL side_clr_err: got %b want 0", cfg_err); end
        n_total++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL side_clr_ready: got %b want 1", cfg_ready); end
        n_total++; if (cfg_busy !== 1'b0) begin n_bad++; $display("FAIL side_clr_busy: got %b want 0", cfg_busy); end
    endtask

    task automatic test_index_range();
        send_header(0);
        send_word(6'b100001, 0);
        send_word(6'b011100, 0);
        for (int k = 2; k < 10; k++) send_word('0, 0);
        n_total++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL idx_edge_legal: got %b want 0", cfg_err); end
        send_word(6'b100010, 0);
        n_total++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL idx_err: got %b want 1", cfg_err); end
        n_total++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL idx_ready: got %b want 0", cfg_ready); end
        n_total++; if (cfg_q !== exp_q) begin n_bad++; $display("FAIL idx_q_kept: got %h want %h", cfg_q, exp_q); end
        do_clr();
    endtask

    task automatic test_stall_abort();
        int d0;
        exp_pat = '0;
        for (int k = 0; k < NW; k++) exp_pat[k*WB +: WB] = pat(k);
        d0 = done_cnt;
        send_header(3);
        for (int k = 0; k < NW; k++) send_word(pat(k), 3);
        idle(1);
        n_total++; if (cfg_q !== exp_pat) begin n_bad++; $display("FAIL stall_q: got %h want %h", cfg_q, exp_pat); end
        idle(4);
        n_total++; if (done_cnt !== d0 + 1) begin n_bad++; $display("FAIL stall_done_count: got %0d want %0d", done_cnt, d0 + 1); end
        d0 = done_cnt;
        send_header(0);
        for (int k = 0; k < 10; k++) send_word('0, 0);
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        cfg_clr   = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        cfg_clr   = 1'b0;
        n_total++; if (cfg_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", cfg_busy); end
        n_total++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL abort_err: got %b want 0", cfg_err); end
        for (int k = 10; k < NW; k++) send_word('0, 0);
        idle(3);
        n_total++; if (done_cnt !== d0) begin n_bad++; $display("FAIL abort_no_done: got %0d want %0d", done_cnt, d0); end
        n_total++; if (cfg_q !== exp_pat) begin n_bad++; $display("FAIL abort_q_kept: got %h want %h", cfg_q, exp_pat); end
    endtask

    task automatic test_reset_midframe();
        send_header(0);
        for (int k = 0; k < 5; k++) send_word(pat(k), 0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        n_total++; if (cfg_q !== '0) begin n_bad++; $display("FAIL midrst_q: got %h want 0", cfg_q); end
        n_total++; if (cfg_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", cfg_busy); end
        n_total++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", cfg_ready); end
        send_header(0);
        for (int k = 0; k < NW; k++) send_word(pat(k), 0);
        idle(1);
        n_total++; if (cfg_q !== exp_pat) begin n_bad++; $display("FAIL midrst_reload_q: got %h want %h", cfg_q, exp_pat); end
        n_total++; if (cfg_done !== 1'b1) begin n_bad++; $display("FAIL midrst_reload_done: got %b want 1", cfg_done); end
    endtask

`ifdef MATRIX_CFG_PARITY_EN
    task automatic test_parity();
        logic [LW-1:0] e;
        send_header(0);
        for (int k = 0; k < 7; k++) send_word(pat(k), 0);
        e = enc(pat(7));
        e[0] = ~e[0];
        for (int i = LW-1; i >= 1; i--) send_bit(e[i]);
        n_total++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL par_err_early: got %b want 0", cfg_err); end
        send_bit(e[0]);
        n_total++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL par_err: got %b want 1", cfg_err); end
        n_total++; if (cfg_q !== exp_pat) begin n_bad++; $display("FAIL par_q_kept: got %h want %h", cfg_q, exp_pat); end
        do_clr();
        n_total++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL par_clr: got %b want 0", cfg_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_legal();
        test_illegal_side();
        test_index_range();
        test_stall_abort();
        test_reset_midframe();
`ifdef MATRIX_CFG_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
